// File: rtl/rtc_field_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_seq_pkg : shared states, RTC field addresses and defaults for the
//               time/date field sequencer.              Revision: 1.0
// ----------------------------------------------------------------------------
package rtc_seq_pkg;

  localparam int NUM_FIELDS_DEF = 6;
  localparam int TIMEOUT_DEF    = 255;

  localparam int FLD_SEC   = 0;
  localparam int FLD_MIN   = 1;
  localparam int FLD_HOUR  = 2;
  localparam int FLD_DAY   = 3;
  localparam int FLD_MONTH = 4;
  localparam int FLD_YEAR  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] FIELD_ADDR [0:5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};

  // Indices beyond the known register map address nothing.
  function automatic logic [7:0] field_addr(input int unsigned idx);
    logic [2:0] sel;
    sel = idx[2:0];
    if (idx < 6) field_addr = FIELD_ADDR[sel];
    else         field_addr = 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_field_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_field_sequencer_if : request/acknowledge RTC register bus.
//                                                       Revision: 1.0
// ----------------------------------------------------------------------------
interface rtc_field_sequencer_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/rtc_field_sequencer_timeout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_bus_timeout : loadable down-counter that flags an unanswered request
//                   after TIMEOUT enabled cycles.          Revision: 1.0
// ----------------------------------------------------------------------------
module rtc_bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic load,
  input  wire logic enable,
  output logic      expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                          count <= '0;
    else if (load)                      count <= LOAD_VAL;
    else if (enable && count != '0)     count <= count - 1'b1;
  end

  // Counting from TIMEOUT-1 makes the TIMEOUT-th request cycle the expiring one.
  assign expired = enable && (count == '0);
endmodule
`default_nettype wire

// File: rtl/rtc_field_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_field_sequencer : reads RTC fields into display registers, or writes a
//                       snapshot of edited fields back.      Revision: 1.0
// ----------------------------------------------------------------------------
module rtc_field_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int NUM_FIELDS = NUM_FIELDS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    seleccion,
  input  wire logic                    tick_refresh,
  input  wire logic                    edit_commit,
  input  wire logic [8*NUM_FIELDS-1:0] edit_values,
  rtc_field_sequencer_if.master        bus,
  output logic [NUM_FIELDS-1:0]        field_load,
  output logic [7:0]                   field_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout
);
  localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FIELDS - 1);

  state_t                  state, state_next;
  logic [IW-1:0]           index;
  logic                    pending;
  logic [8*NUM_FIELDS-1:0] snapshot;
  logic [7:0]              rdata_q;
  logic                    skip;
  logic                    err_q;

  logic last, start_write, start_read, in_xfer, expired;

  assign last        = (index == LAST_IDX);
  assign start_write = edit_commit && seleccion;
  assign start_read  = (tick_refresh || pending) && !seleccion;
  assign in_xfer     = (state == ST_READ) || (state == ST_WRITE);

  rtc_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (!in_xfer),
    .enable  (in_xfer),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = 8'h00;
    bus.wdata  = 8'h00;
    field_load = '0;
    field_data = 8'h00;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (start_write)     state_next = ST_WRITE;
        else if (start_read) state_next = ST_READ;
      end
      ST_READ: begin
        bus.req  = 1'b1;
        bus.addr = field_addr(32'(index));
        if (bus.ack || expired) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (!skip) begin
          field_load = NUM_FIELDS'(1) << index;
          field_data = rdata_q;
        end
        done       = last;
        state_next = last ? ST_IDLE : ST_READ;
      end
      ST_WRITE: begin
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = field_addr(32'(index));
        bus.wdata = snapshot[{index, 3'b000} +: 8];
        if (bus.ack || expired) state_next = ST_GAP;
      end
      ST_GAP: begin
        done       = last;
        state_next = last ? ST_IDLE : ST_WRITE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= '0;
      pending  <= 1'b0;
      snapshot <= '0;
      rdata_q  <= 8'h00;
      skip     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // Pending is consumed or discarded by IDLE; only a busy tick arms it.
      if (state == ST_IDLE)  pending <= 1'b0;
      else if (tick_refresh) pending <= 1'b1;

      if (state == ST_IDLE && (start_write || start_read)) begin
        index <= '0;
        err_q <= 1'b0;
        if (start_write) snapshot <= edit_values;
      end

      if ((state == ST_LOAD || state == ST_GAP) && !last)
        index <= index + 1'b1;

      if (in_xfer) begin
        skip <= !bus.ack;
        if (expired && !bus.ack) err_q <= 1'b1;
      end

      if (state == ST_READ && bus.ack) rdata_q <= bus.rdata;
    end
  end

  assign err_timeout = err_q;
endmodule
`default_nettype wire

// File: tb/tb_rtc_field_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rtc_field_sequencer : scoreboard bench for rtc_field_sequencer.
//                                                       Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rtc_field_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        seleccion;
  logic        tick_refresh;
  logic        edit_commit;
  logic [47:0] edit_values;
  logic [5:0]  field_load;
  logic [7:0]  field_data;
  logic        busy, done, err_timeout;

  rtc_field_sequencer_if bus ();

  rtc_field_sequencer #(.NUM_FIELDS(6), .TIMEOUT(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .seleccion    (seleccion),
    .tick_refresh (tick_refresh),
    .edit_commit  (edit_commit),
    .edit_values  (edit_values),
    .bus          (bus),
    .field_load   (field_load),
    .field_data   (field_data),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_load;
    logic [7:0] we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [5:0] load;
    logic [7:0] data;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] no_ack_addr = 8'h00;
  int month_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    exp_t e;
    e = '{is_load: 1'b0, we: {7'd0, we}, addr: addr, wdata: wdata, load: 6'd0, data: 8'd0, dn: 1'b0};
    q.push_back(e);
  endtask

  task automatic push_load(input int idx, input logic [7:0] data, input logic dn);
    exp_t e;
    e = '{is_load: 1'b1, we: 8'd0, addr: 8'd0, wdata: 8'd0, load: 6'(1 << idx), data: data, dn: dn};
    q.push_back(e);
  endtask

  // Read pass expectation; skip_idx < 0 means every field answers.
  task automatic push_read_pass(input int skip_idx);
    for (int i = 0; i < 6; i++) begin
      push_bus(1'b0, 8'(8'h21 + i), 8'h00);
      if (i != skip_idx) push_load(i, 8'(8'h10 + i), i == 5);
    end
  endtask

  // Bus responder: acks the third cycle of a request, except for no_ack_addr.
  initial begin
    int rcnt;
    rcnt      = 0;
    bus.ack   = 1'b0;
    bus.rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.ack) begin
        bus.ack = 1'b0;
        rcnt    = 0;
      end else if (bus.req) begin
        rcnt++;
        if (rcnt == 3 && bus.addr != no_ack_addr) begin
          bus.ack   = 1'b1;
          bus.rdata = 8'h10 + (bus.addr - 8'h21);
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every new request and every load strobe.
  initial begin
    logic       prev_req;
    int         run;
    logic [7:0] run_addr;
    exp_t       e;
    prev_req = 1'b0;
    run      = 0;
    run_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.req && !prev_req) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus: addr %h we %b", bus.addr, bus.we);
        end else begin
          e = q.pop_front();
          check("bus_kind", {63'd0, 1'b0}, {63'd0, e.is_load});
          check("bus_xfer", {bus.we, bus.addr, bus.wdata}, {e.we[0], e.addr, e.wdata});
        end
      end
      if (field_load != 6'd0) begin
        check("load_onehot", {63'd0, $onehot(field_load)}, 64'd1);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: load %h data %h", field_load, field_data);
        end else begin
          e = q.pop_front();
          check("load_kind", {63'd0, 1'b1}, {63'd0, e.is_load});
          check("load_strobe", {field_load, field_data, done}, {e.load, e.data, e.dn});
        end
      end
      if (bus.req) begin
        run++;
        run_addr = bus.addr;
      end else begin
        if (run > 0 && run_addr == 8'h25) month_run = run;
        run = 0;
      end
      prev_req = bus.req;
    end
  end

  task automatic pulse_tick;
    @(negedge clk) tick_refresh = 1'b1;
    @(negedge clk) tick_refresh = 1'b0;
  endtask

  task automatic pulse_commit;
    @(negedge clk) edit_commit = 1'b1;
    @(negedge clk) edit_commit = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {63'd0, seen}, 64'd1);
  endtask

  task automatic idle_for(input string name, input int cycles);
    bit saw_busy;
    saw_busy = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check(name, {63'd0, saw_busy}, 64'd0);
  endtask

  initial begin
    bit seen;
    reset        = 1'b1;
    seleccion    = 1'b0;
    tick_refresh = 1'b0;
    edit_commit  = 1'b0;
    edit_values  = 48'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.req, bus.we, bus.addr, bus.wdata, field_load, field_data, busy, done, err_timeout},
          '0);
    @(negedge clk) reset = 1'b0;

    // Read pass with latency check.
    push_read_pass(-1);
    pulse_tick();
    check("tick_to_req", {bus.req, bus.we, bus.addr}, {1'b1, 1'b0, 8'h21});
    wait_done("read_done", 200);
    @(negedge clk);
    check("busy_after_read", {63'd0, busy}, 64'd0);
    check("read_err", {63'd0, err_timeout}, 64'd0);

    // Write pass: snapshot must survive edit_values changing after commit.
    seleccion   = 1'b1;
    edit_values = 48'h16_05_31_23_59_45;
    push_bus(1'b1, 8'h21, 8'h45);
    push_bus(1'b1, 8'h22, 8'h59);
    push_bus(1'b1, 8'h23, 8'h23);
    push_bus(1'b1, 8'h24, 8'h31);
    push_bus(1'b1, 8'h25, 8'h05);
    push_bus(1'b1, 8'h26, 8'h16);
    pulse_commit();
    edit_values = 48'hAA_BB_CC_DD_EE_FF;
    wait_done("write_done", 200);
    check("write_drained", 64'(q.size()), 64'd0);

    // Timeout on the month read.
    seleccion   = 1'b0;
    no_ack_addr = 8'h25;
    push_read_pass(4);
    pulse_tick();
    wait_done("timeout_done", 2000);
    check("timeout_err", {63'd0, err_timeout}, 64'd1);
    check("timeout_req_len", 64'(month_run), 64'd255);
    check("timeout_drained", 64'(q.size()), 64'd0);

    // Three ticks mid-pass collapse into one extra pass, which clears err.
    no_ack_addr = 8'h22;
    push_read_pass(1);
    push_read_pass(-1);
    pulse_tick();
    repeat (5) @(negedge clk);
    repeat (3) pulse_tick();
    wait_done("pending_first_done", 2000);
    no_ack_addr = 8'h00;
    check("pending_err_set", {63'd0, err_timeout}, 64'd1);
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("pending_restart", {62'd0, seen, err_timeout}, {62'd0, 1'b1, 1'b0});
    wait_done("pending_second_done", 200);
    idle_for("no_third_pass", 10);
    check("pending_drained", 64'(q.size()), 64'd0);

    // Commit + tick in edit mode writes only; commit in read mode is dropped.
    seleccion   = 1'b1;
    edit_values = 48'h06_05_04_03_02_01;
    for (int i = 0; i < 6; i++) push_bus(1'b1, 8'(8'h21 + i), 8'(i + 1));
    @(negedge clk);
    edit_commit  = 1'b1;
    tick_refresh = 1'b1;
    @(negedge clk);
    edit_commit  = 1'b0;
    tick_refresh = 1'b0;
    wait_done("simul_done", 200);
    idle_for("simul_no_read", 8);
    seleccion = 1'b0;
    pulse_commit();
    idle_for("commit_read_mode", 6);

    // Reset while waiting on the hour read.
    no_ack_addr = 8'h23;
    push_bus(1'b0, 8'h21, 8'h00);
    push_load(0, 8'h10, 1'b0);
    push_bus(1'b0, 8'h22, 8'h00);
    push_load(1, 8'h11, 1'b0);
    push_bus(1'b0, 8'h23, 8'h00);
    pulse_tick();
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.req && bus.addr == 8'h23) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_hour", {63'd0, seen}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midpass_reset",
          {bus.req, bus.we, bus.addr, bus.wdata, field_load, field_data, busy, done, err_timeout},
          '0);
    @(negedge clk);
    reset       = 1'b0;
    no_ack_addr = 8'h00;
    push_read_pass(-1);
    pulse_tick();
    check("restart_addr", {bus.req, bus.addr}, {1'b1, 8'h21});
    wait_done("restart_done", 200);
    repeat (2) @(negedge clk);
    check("final_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
`default_nettype wire
